mem_fill_responder: RTL
=======================

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from read issue to data_valid; legal range 1..8.
REQ-002 Parameter ADDR_W, default 15: word-address bits; the array holds 2^ADDR_W 16-bit words.
REQ-003 Reset is asynchronous and active-high; one clock; ports named clk and rst as elsewhere in the codebase.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 enable  input  1  request strobe; one request per cycle.
REQ-007 wr  input  1  1 = write request, 0 = read request; qualified by enable.
REQ-008 addr  input  16  byte address; word index = addr[ADDR_W:1].
REQ-009 data_in  input  16  write data.
REQ-010 flush  input  1  kills all in-flight reads.
REQ-011 data_out  output  16  read data; meaningful only when data_valid=1.
REQ-012 data_valid  output  1  data_out carries a read result this cycle.
REQ-013 inflight  output  4  count of reads issued and not yet returned or flushed.
REQ-014 idle  output  1  1 when inflight==0.

Function
REQ-015 Read issue (enable=1, wr=0) SHALL sample array[addr[ADDR_W:1]] at that rising edge and enter it into a LATENCY-deep valid/data shift pipeline.
REQ-016 The read issued at edge N SHALL appear with data_valid=1 for exactly one cycle, after edge N+LATENCY-1, i.e. LATENCY cycles after issue; order SHALL be preserved.
REQ-017 Back-to-back reads every cycle SHALL return back-to-back with no bubbles; 8 consecutive reads yield 8 consecutive data_valid cycles.
REQ-018 Write (enable=1, wr=1) SHALL update the array at the issuing edge, produce no data_valid, and not disturb in-flight reads.
REQ-019 Reads in flight SHALL return data sampled at their issue edge; a later write to the same word SHALL NOT alter them.
REQ-020 A read issued the cycle after a write to the same word SHALL return the written data.
REQ-021 enable=0 cycles SHALL insert bubbles (data_valid=0) in the pipeline at the corresponding positions.
REQ-022 flush=1 SHALL clear every pipeline valid bit at that edge; a request issued in the same cycle as flush SHALL be accepted into the cleared pipeline, not dropped.
REQ-023 inflight SHALL increment on read issue, decrement on data_valid, both together leave it unchanged; on flush it SHALL become 1 if a read was issued that cycle, else 0; it never exceeds LATENCY.
REQ-024 data_out SHALL be 16'h0000 whenever data_valid=0.

Reset
REQ-025 rst SHALL asynchronously clear all pipeline valid bits, data_out, data_valid, inflight to 0 and drive idle to 1.
REQ-026 Array contents SHALL NOT be reset; reads of never-written words return undefined data.
REQ-027 Reset asserted mid-burst SHALL discard all in-flight reads; no data_valid appears after rst deasserts until a new read completes.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN: when defined, an odd-address read (addr[0]=1) SHALL return 16'hDEAD with data_valid=1 at normal latency and odd-address writes SHALL be ignored; when undefined, addr[0] SHALL be ignored for reads and writes.

Verification
REQ-029 Write 8 words 0x1000..0x100E with data 0xA0..0xA7, then 8 back-to-back reads from 0x1000 -> 8 consecutive data_valid cycles starting 4 cycles after first read, data 0xA0..0xA7 in order, inflight peaks at 4.
REQ-030 Read 0x2000 (holds 0x1111), next cycle write 0x2000=0x2222, next cycle read 0x2000 -> returns 0x1111 then 0x2222.
REQ-031 Issue reads at cycles 0,2,3 -> data_valid at cycles 4,6,7 only.
REQ-032 3 reads in flight, flush with new read 0x3000 same cycle -> only 0x3000 data returns, inflight goes 3->1->0.
REQ-033 rst pulsed with 4 reads in flight -> data_valid=0, inflight=0, idle=1 immediately and for the following 8 idle cycles.
REQ-034 With MEM_ALIGN_CHECK_EN, read 0x0001 -> data_out=0xDEAD at latency 4; write 0x0003=0x5555 leaves word 0x0002 unchanged.

Source files
------------

// File: rtl/mem_fill_responder.sv
// Word-addressed 16-bit memory model with a fixed-latency, flushable read-return pipeline.
// Optional feature macro: MEM_ALIGN_CHECK_EN (odd-address reads return 16'hDEAD, odd writes dropped).
module mem_fill_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        flush,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  inflight,
  output logic        idle
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]  r_dat [LATENCY];
  logic [CNT_W-1:0]   r_inflight;
  logic               r_idle;

  logic [ADDR_W-1:0]  w_idx;
  logic               w_rd;
  logic               w_wr;
  logic [DATA_W-1:0]  w_rd_data;
  logic [CNT_W-1:0]   w_inflight_nxt;

  assign w_idx = addr[ADDR_W:1];
  assign w_rd  = enable && !wr;

`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [DATA_W-1:0] MISALIGN_DATA = 16'hDEAD;
  assign w_wr      = enable && wr && !addr[0];
  assign w_rd_data = addr[0] ? MISALIGN_DATA : r_mem[w_idx];
`else
  logic w_unused;
  assign w_unused  = addr[0];
  assign w_wr      = enable && wr;
  assign w_rd_data = r_mem[w_idx];
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Flush restarts the count from just the read issued alongside it.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (flush) begin
      w_inflight_nxt = w_rd ? CNT_W'(1) : CNT_W'(0);
    end else begin
      w_inflight_nxt = r_inflight + CNT_W'(w_rd) - CNT_W'(r_vld[LATENCY-1]);
    end
  end

  // Data is zeroed alongside its valid bit so the output stage reads 0 on bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= '0;
      r_inflight <= '0;
      r_idle     <= 1'b1;
      for (int i = 0; i < LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0]   <= w_rd;
      r_dat[0]   <= w_rd ? w_rd_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1] && !flush;
        r_dat[i] <= flush ? '0 : r_dat[i-1];
      end
      r_inflight <= w_inflight_nxt;
      r_idle     <= (w_inflight_nxt == CNT_W'(0));
    end
  end

  assign data_out   = r_dat[LATENCY-1];
  assign data_valid = r_vld[LATENCY-1];
  assign inflight   = r_inflight;
  assign idle       = r_idle;

endmodule
